// File: rtl/fb_swap_ctrl.sv
// Display-side framebuffer swap controller: queues finished-frame addresses and
// commits each to display_addr either immediately or on a vsync rising edge.
module fb_swap_ctrl #(
   parameter int                    ADDR_WIDTH         = 25,
   parameter int                    PENDING_DEPTH      = 2,
   parameter int                    MODE               = 0,
   parameter logic [ADDR_WIDTH-1:0] DISPLAY_RESET_ADDR = '0,
   parameter int                    CNT_WIDTH          = 16
) (
   input  logic                               aclk,
   input  logic                               rst,
   input  logic                               swap_fb,
   input  logic                               swap_fb_enable_vsync,
   input  logic [ADDR_WIDTH-1:0]              fb_addr,
   output logic                               swap_ready,
   output logic                               fb_swapped,
   input  logic                               vsync,
   output logic [ADDR_WIDTH-1:0]              display_addr,
   output logic [$clog2(PENDING_DEPTH):0]     pending,
   output logic [CNT_WIDTH-1:0]               frame_count,
   output logic [CNT_WIDTH-1:0]               dropped_count
);

   localparam int              PTR_W    = $clog2(PENDING_DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT = PENDING_DEPTH[PTR_W:0];
   localparam logic [PTR_W:0]  ONE_CNT  = {{PTR_W{1'b0}}, 1'b1};

   logic [ADDR_WIDTH-1:0] q_addr [PENDING_DEPTH];
   logic                  q_vs   [PENDING_DEPTH];
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [PTR_W-1:0]      wr_idx;
   logic                  vsync_q;
   logic                  vs_edge;
   logic                  full;
   logic                  accept;
   logic                  commit;
   logic                  overwrite;
   logic [PTR_W:0]        pending_nxt;

   // Commit looks only at the start-of-cycle head, so a same-cycle accept is never committed.
   always_comb begin
      vs_edge     = vsync && !vsync_q;
      full        = (pending == FULL_CNT);
      accept      = swap_fb && swap_ready;
      commit      = (pending != '0) && (!q_vs[head] || vs_edge);
      overwrite   = accept && full && !commit && (MODE == 1);
      wr_idx      = overwrite ? (tail - PTR_W'(1)) : tail;
      pending_nxt = pending;
      if (accept && !overwrite && !commit)
         pending_nxt = pending + ONE_CNT;
      else if (commit && !accept)
         pending_nxt = pending - ONE_CNT;
   end

   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         head          <= '0;
         tail          <= '0;
         pending       <= '0;
         swap_ready    <= 1'b1;
         fb_swapped    <= 1'b0;
         vsync_q       <= 1'b0;
         display_addr  <= DISPLAY_RESET_ADDR;
         frame_count   <= '0;
         dropped_count <= '0;
      end else begin
         vsync_q    <= vsync;
         fb_swapped <= commit;
         pending    <= pending_nxt;
         swap_ready <= (MODE == 1) || (pending_nxt != FULL_CNT);
         if (commit) begin
            display_addr <= q_addr[head];
            head         <= head + PTR_W'(1);
         end
         if (accept && !overwrite)
            tail <= tail + PTR_W'(1);
         if (vs_edge)
            frame_count <= frame_count + CNT_WIDTH'(1);
         if (overwrite)
            dropped_count <= dropped_count + CNT_WIDTH'(1);
      end
   end

   // Queue storage carries no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge aclk) begin
      if (accept) begin
         q_addr[wr_idx] <= fb_addr;
         q_vs[wr_idx]   <= swap_fb_enable_vsync;
      end
   end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: a FIFO and a MAILBOX instance share stimulus and are
// scored against a queue-based reference model.
module tb_fb_swap_ctrl;

   localparam int             AW       = 25;
   localparam int             DEPTH    = 2;
   localparam int             CW       = 16;
   localparam logic [AW-1:0]  RST_ADDR = 25'h00ABCDE;

   typedef struct packed {
      logic          vs;
      logic [AW-1:0] addr;
   } ent_t;

   logic          aclk    = 1'b0;
   logic          rst     = 1'b1;
   logic          rst_req = 1'b1;
   logic          swap_fb = 1'b0;
   logic          swap_vs = 1'b0;
   logic          vsync   = 1'b0;
   logic [AW-1:0] fb_addr = '0;

   logic          ready   [2];
   logic          swapped [2];
   logic [AW-1:0] disp    [2];
   logic [1:0]    pend    [2];
   logic [CW-1:0] frames  [2];
   logic [CW-1:0] drops   [2];

   ent_t          mq    [2][$];
   logic [AW-1:0] exp_q [2][$];
   logic          m_vq;
   logic          m_swapped [2];
   logic          m_ready   [2];
   logic [AW-1:0] m_disp    [2];
   logic [CW-1:0] m_frame   [2];
   logic [CW-1:0] m_drop    [2];
   logic [AW-1:0] mon_want;

   int n_chk  = 0;
   int n_fail = 0;

   fb_swap_ctrl #(.ADDR_WIDTH(AW), .PENDING_DEPTH(DEPTH), .MODE(0),
                  .DISPLAY_RESET_ADDR(RST_ADDR), .CNT_WIDTH(CW)) u_fifo (
      .aclk(aclk), .rst(rst), .swap_fb(swap_fb), .swap_fb_enable_vsync(swap_vs),
      .fb_addr(fb_addr), .swap_ready(ready[0]), .fb_swapped(swapped[0]),
      .vsync(vsync), .display_addr(disp[0]), .pending(pend[0]),
      .frame_count(frames[0]), .dropped_count(drops[0]));

   fb_swap_ctrl #(.ADDR_WIDTH(AW), .PENDING_DEPTH(DEPTH), .MODE(1),
                  .DISPLAY_RESET_ADDR(RST_ADDR), .CNT_WIDTH(CW)) u_mbox (
      .aclk(aclk), .rst(rst), .swap_fb(swap_fb), .swap_fb_enable_vsync(swap_vs),
      .fb_addr(fb_addr), .swap_ready(ready[1]), .fb_swapped(swapped[1]),
      .vsync(vsync), .display_addr(disp[1]), .pending(pend[1]),
      .frame_count(frames[1]), .dropped_count(drops[1]));

   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, d, $time, act, want);
      end
   endtask

   task automatic model_reset();
      m_vq = 1'b0;
      for (int d = 0; d < 2; d++) begin
         mq[d].delete();
         m_swapped[d] = 1'b0;
         m_ready[d]   = 1'b1;
         m_disp[d]    = RST_ADDR;
         m_frame[d]   = '0;
         m_drop[d]    = '0;
      end
   endtask

   // Drive one cycle of inputs and advance the model across the coming rising edge.
   task automatic cyc(input logic sw, input logic ve, input logic [AW-1:0] a, input logic v);
      logic edge_seen;
      logic is_full;
      logic acc;
      logic com;
      ent_t e;
      @(negedge aclk);
      rst     = rst_req;
      swap_fb = sw;
      swap_vs = ve;
      fb_addr = a;
      vsync   = v;
      if (rst_req) begin
         model_reset();
      end else begin
         edge_seen = v && !m_vq;
         for (int d = 0; d < 2; d++) begin
            is_full = (mq[d].size() == DEPTH);
            acc     = sw && ((d == 1) || !is_full);
            com     = (mq[d].size() != 0) && (!mq[d][0].vs || edge_seen);
            if (com) begin
               e = mq[d].pop_front();
               exp_q[d].push_back(e.addr);
               m_disp[d] = e.addr;
            end
            if (acc) begin
               if ((d == 1) && is_full && !com) begin
                  mq[d][mq[d].size()-1] = '{vs: ve, addr: a};
                  m_drop[d]++;
               end else begin
                  mq[d].push_back('{vs: ve, addr: a});
               end
            end
            m_swapped[d] = com;
            if (edge_seen) m_frame[d]++;
            m_ready[d] = (d == 1) || (mq[d].size() != DEPTH);
         end
         m_vq = v;
      end
   endtask

   task automatic idle(input int n, input logic v);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, v);
   endtask

   task automatic rst_pulse(input int n);
      rst_req = 1'b1;
      idle(n, 1'b0);
      rst_req = 1'b0;
   endtask

   // Monitor: pops an expected address on every fb_swapped pulse and tracks all outputs.
   initial begin
      forever begin
         @(posedge aclk);
         #1;
         for (int d = 0; d < 2; d++) begin
            if (swapped[d]) begin
               if (exp_q[d].size() == 0) begin
                  chk("unexpected_swap", d, 32'd1, 32'd0);
               end else begin
                  mon_want = exp_q[d].pop_front();
                  chk("swap_addr", d, 32'(disp[d]), 32'(mon_want));
               end
            end
            chk("fb_swapped", d, 32'(swapped[d]), 32'(m_swapped[d]));
            chk("pending", d, 32'(pend[d]), 32'(mq[d].size()));
            chk("swap_ready", d, 32'(ready[d]), 32'(m_ready[d]));
            chk("display_addr", d, 32'(disp[d]), 32'(m_disp[d]));
            chk("frame_count", d, 32'(frames[d]), 32'(m_frame[d]));
            chk("dropped_count", d, 32'(drops[d]), 32'(m_drop[d]));
         end
      end
   end

   initial begin
      logic vlev;
      model_reset();
      idle(3, 1'b0);
      for (int d = 0; d < 2; d++) begin
         chk("rst_disp", d, 32'(disp[d]), 32'(RST_ADDR));
         chk("rst_pending", d, 32'(pend[d]), 32'd0);
         chk("rst_ready", d, 32'(ready[d]), 32'd1);
      end
      rst_req = 1'b0;

      // Single immediate request
      cyc(1'b1, 1'b0, 25'h0100000, 1'b0);
      idle(1, 1'b0);
      chk("imm_pend_mid", 0, 32'(pend[0]), 32'd1);
      chk("imm_disp_mid", 0, 32'(disp[0]), 32'(RST_ADDR));
      idle(1, 1'b0);
      chk("imm_disp", 0, 32'(disp[0]), 32'h0100000);
      chk("imm_pend", 0, 32'(pend[0]), 32'd0);
      idle(2, 1'b0);

      // Vsync request, then vsync held high
      cyc(1'b1, 1'b1, 25'h0200000, 1'b0);
      idle(3, 1'b0);
      chk("vs_wait_pend", 0, 32'(pend[0]), 32'd1);
      chk("vs_wait_disp", 0, 32'(disp[0]), 32'h0100000);
      idle(10, 1'b1);
      idle(1, 1'b0);
      chk("vs_disp", 0, 32'(disp[0]), 32'h0200000);
      chk("vs_frames", 0, 32'(frames[0]), 32'd1);

      // FIFO back-pressure: A, B queued, C held until space frees
      cyc(1'b1, 1'b1, 25'h0A0000A, 1'b0);
      cyc(1'b1, 1'b1, 25'h0B0000B, 1'b0);
      cyc(1'b1, 1'b1, 25'h0C0000C, 1'b0);
      cyc(1'b1, 1'b1, 25'h0C0000C, 1'b0);
      chk("fifo_full_ready", 0, 32'(ready[0]), 32'd0);
      chk("fifo_full_pend", 0, 32'(pend[0]), 32'd2);
      cyc(1'b1, 1'b1, 25'h0C0000C, 1'b1);
      cyc(1'b1, 1'b1, 25'h0C0000C, 1'b0);
      chk("fifo_disp_a", 0, 32'(disp[0]), 32'h0A0000A);
      idle(1, 1'b0);
      idle(1, 1'b1);
      idle(1, 1'b0);
      chk("fifo_disp_b", 0, 32'(disp[0]), 32'h0B0000B);
      idle(1, 1'b1);
      idle(2, 1'b0);
      chk("fifo_disp_c", 0, 32'(disp[0]), 32'h0C0000C);
      chk("fifo_drops", 0, 32'(drops[0]), 32'd0);

      // Reset mid-queue
      cyc(1'b1, 1'b1, 25'h0111111, 1'b0);
      cyc(1'b1, 1'b1, 25'h0122222, 1'b0);
      idle(1, 1'b0);
      chk("pre_rst_pend", 0, 32'(pend[0]), 32'd2);
      rst_pulse(3);
      idle(1, 1'b0);
      for (int d = 0; d < 2; d++) begin
         chk("post_rst_pend", d, 32'(pend[d]), 32'd0);
         chk("post_rst_disp", d, 32'(disp[d]), 32'(RST_ADDR));
         chk("post_rst_frames", d, 32'(frames[d]), 32'd0);
         chk("post_rst_drops", d, 32'(drops[d]), 32'd0);
      end

      // Mailbox: A, B, C, D with no vsync
      cyc(1'b1, 1'b1, 25'h00000A1, 1'b0);
      cyc(1'b1, 1'b1, 25'h00000B2, 1'b0);
      cyc(1'b1, 1'b1, 25'h00000C3, 1'b0);
      cyc(1'b1, 1'b1, 25'h00000D4, 1'b0);
      idle(1, 1'b0);
      chk("mb_pend", 1, 32'(pend[1]), 32'd2);
      chk("mb_drops", 1, 32'(drops[1]), 32'd2);
      chk("mb_fifo_pend", 0, 32'(pend[0]), 32'd2);
      idle(1, 1'b1);
      idle(1, 1'b0);
      chk("mb_disp_a", 1, 32'(disp[1]), 32'h00000A1);
      idle(1, 1'b1);
      idle(1, 1'b0);
      chk("mb_disp_d", 1, 32'(disp[1]), 32'h00000D4);
      chk("mb_fifo_disp_b", 0, 32'(disp[0]), 32'h00000B2);

      // Vsync head blocks an immediate entry behind it
      cyc(1'b1, 1'b1, 25'h0123400, 1'b0);
      cyc(1'b1, 1'b0, 25'h0567800, 1'b0);
      idle(3, 1'b0);
      chk("mix_pend", 0, 32'(pend[0]), 32'd2);
      idle(1, 1'b1);
      idle(1, 1'b0);
      chk("mix_disp_x", 0, 32'(disp[0]), 32'h0123400);
      chk("mix_disp_x_mb", 1, 32'(disp[1]), 32'h0123400);
      idle(1, 1'b0);
      chk("mix_disp_y", 0, 32'(disp[0]), 32'h0567800);
      chk("mix_disp_y_mb", 1, 32'(disp[1]), 32'h0567800);

      // Randomized traffic
      vlev = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) vlev = !vlev;
         cyc(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), AW'($urandom), vlev);
      end

      // Drain remaining vsync entries
      for (int i = 0; i < 6; i++) begin
         idle(1, 1'b1);
         idle(1, 1'b0);
      end
      idle(3, 1'b0);
      for (int d = 0; d < 2; d++) begin
         chk("drain_pend", d, 32'(pend[d]), 32'd0);
         chk("unseen_swaps", d, 32'(exp_q[d].size()), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_swap_ctrl.md
Name: fb_swap_ctrl

Overview:
- Display-side framebuffer swap controller. Sits between the rasterizer's swap interface (swap_fb, swap_fb_enable_vsync, fb_addr, fb_swapped) and the display scan-out engine.
- Queues finished-frame addresses and commits each one to display_addr, either immediately or on a vsync rising edge.
- Supports a FIFO mode (every frame shown) and a MAILBOX mode (newest frame wins, older pending frames are dropped). Generalises double buffering to N-deep pending queues.

Parameters:
- ADDR_WIDTH, 25: width of framebuffer addresses.
- PENDING_DEPTH, 2: pending-queue depth; power of two, ≥2.
- MODE, 0: 0 = FIFO, 1 = MAILBOX.
- DISPLAY_RESET_ADDR, 0: display_addr value after reset.
- CNT_WIDTH, 16: width of frame_count and dropped_count.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- swap_fb  in  1  swap request valid.
- swap_fb_enable_vsync  in  1  request commits on vsync (1) or immediately (0); sampled with swap_fb.
- fb_addr  in  ADDR_WIDTH  address of the finished frame; sampled with swap_fb.
- swap_ready  out  1  request can be accepted this cycle.
- fb_swapped  out  1  one-cycle pulse when an entry is committed to display_addr.
- vsync  in  1  vertical-blank level, synchronous to aclk.
- display_addr  out  ADDR_WIDTH  address the scan-out engine reads.
- pending  out  log2(PENDING_DEPTH)+1  number of queued entries.
- frame_count  out  CNT_WIDTH  count of vsync rising edges.
- dropped_count  out  CNT_WIDTH  count of frames overwritten in MAILBOX mode.

Behaviour:
- Reset values:
  - display_addr = DISPLAY_RESET_ADDR.
  - fb_swapped, pending, frame_count, dropped_count = 0; queue empty.
  - swap_ready = 1.
  - vsync_q = 0.
  - Reset mid-operation flushes the queue with no fb_swapped pulse.
- Accept:
  - A request is accepted at a clock edge where swap_fb && swap_ready.
  - Entry {fb_addr, swap_fb_enable_vsync} is written at the tail.
- swap_ready:
  - FIFO mode: registered, equals (pending != PENDING_DEPTH) computed from start-of-cycle state.
  - FIFO mode: no accept when full, even if a commit occurs the same cycle.
  - MAILBOX mode: constantly 1.
- MAILBOX full accept:
  - Without a commit the same cycle: the newest entry (tail-1) is overwritten, pending is unchanged, dropped_count increments.
  - With a commit the same cycle: normal push/pop, no drop.
- Vsync edge detect: vsync_q registered; edge = vsync && !vsync_q. frame_count increments on each edge.
- Commit consideration:
  - Only entries present at the start of the cycle are considered; an entry accepted this cycle is never committed this cycle.
  - At most one commit per cycle.
- Commit conditions (head entry valid):
  - Head has vsync flag 0: commit this cycle.
  - Head has vsync flag 1: commit only on a cycle where edge = 1.
  - A vsync-flag-1 head blocks later entries until its edge; later vsync entries each need their own edge.
- Commit effect: at the clock edge, display_addr <= head addr, pop head, fb_swapped = 1 during the following cycle only.
- Latency:
  - Immediate request into an empty queue at edge t gives display_addr updated and fb_swapped high in the cycle after edge t+1.
  - Vsync request: commit in the cycle after the first vsync rising edge detected after acceptance.
- Simultaneous accept and commit: pending is unchanged; pointers both advance.
- Pointers wrap modulo PENDING_DEPTH.
- Counters wrap modulo 2^CNT_WIDTH; no saturation.
- vsync held high produces exactly one edge.

Test Plan:
1. Reset → display_addr = DISPLAY_RESET_ADDR, pending = 0, swap_ready = 1. Single immediate request, fb_addr = 0x100000 → fb_swapped pulses exactly once; display_addr = 0x100000 two edges after acceptance; pending returns to 0.
2. Vsync request, fb_addr = 0x200000 while vsync = 0 → no commit; pending = 1. Raise vsync → commit one cycle after the edge; frame_count +1. Hold vsync high 10 cycles → no further increment.
3. FIFO, PENDING_DEPTH = 2, three back-to-back vsync requests (A, B, C) with no vsync → swap_ready = 0 after two; C stalls. Then 3 vsync pulses → display_addr A, B, C in order; dropped_count = 0.
4. MAILBOX, depth 2, vsync requests A, B, C, D without vsync → pending = 2; dropped_count = 2. Next vsync → A is displayed; next vsync → D is displayed.
5. Mixed: vsync entry X at head, immediate entry Y behind it → Y is not committed until X commits on an edge. Y then commits the following cycle with a separate fb_swapped pulse.
6. Assert rst with pending = 2 mid-queue → pending = 0, display_addr = reset value, no fb_swapped pulse, counters = 0 on release.
